// File: rtl/branch_resolve_stage_if.sv
// Handshake and payload bundle between the execute adder, the branch resolve stage and writeback/redirect.
interface branch_resolve_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [2:0]      in_funct3;
    logic            in_n;
    logic            in_z;
    logic            in_c;
    logic            in_v;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;

    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic [XLEN-1:0] out_target;
    logic [XLEN-1:0] out_result;
    logic            out_misalign;

    modport master (
        output in_valid, in_op, in_funct3, in_n, in_z, in_c, in_v, in_pc, in_imm,
        input  in_ready,
        input  out_valid, out_taken, out_target, out_result, out_misalign,
        output out_ready
    );

    modport slave (
        input  in_valid, in_op, in_funct3, in_n, in_z, in_c, in_v, in_pc, in_imm,
        output in_ready,
        output out_valid, out_taken, out_target, out_result, out_misalign,
        input  out_ready
    );
endinterface

// File: rtl/branch_resolve_stage.sv
// Resolves RISC-V branches and SLT/SLTU from subtract-adder flags, computes pc+imm, and queues results in a 2-entry skid buffer.
// Define BRANCH_RESOLVE_STATS_EN to add the stat_branches / stat_taken counters.
module branch_resolve_stage #(
    parameter int XLEN = 32
) (
    input  logic clk,
    input  logic rst_n,
    branch_resolve_stage_if.slave io_bus
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_taken
`endif
);

    typedef struct packed {
        logic            is_branch;
        logic            taken;
        logic            misalign;
        logic            result;
        logic [XLEN-1:0] target;
    } entry_t;

    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;
    logic            w_cond;
    logic            w_is_branch;
    logic            w_taken;
    logic            w_result;
    logic [XLEN-1:0] w_target;
    entry_t          w_new;

    logic [1:0]      r_count;
    logic            r_in_ready;
    entry_t          r_ent [2];

    logic            w_push;
    logic            w_pop;
    logic [1:0]      w_count_next;
    logic [1:0]      w_wr_idx;
    logic [1:0]      w_wr_en;

    assign w_eq  = io_bus.in_z;
    assign w_lt  = io_bus.in_n ^ io_bus.in_v;
    assign w_ltu = ~io_bus.in_c;

    always_comb begin
        w_cond = 1'b0;
        case (io_bus.in_funct3)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = ~w_eq;
            3'b100:  w_cond = w_lt;
            3'b101:  w_cond = ~w_lt;
            3'b110:  w_cond = w_ltu;
            3'b111:  w_cond = ~w_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_is_branch = (io_bus.in_op == 2'b01);
    assign w_taken     = w_is_branch & w_cond;
    assign w_target    = io_bus.in_pc + io_bus.in_imm;

    always_comb begin
        w_result = 1'b0;
        case (io_bus.in_op)
            2'b10:   w_result = w_lt;
            2'b11:   w_result = w_ltu;
            default: w_result = 1'b0;
        endcase
    end

    always_comb begin
        w_new           = '0;
        w_new.is_branch = w_is_branch;
        w_new.taken     = w_taken;
        w_new.misalign  = w_taken & (w_target[1:0] != 2'b00);
        w_new.result    = w_result;
        w_new.target    = w_target;
    end

    // in_ready is a register, so out_ready never reaches it combinationally.
    assign w_push       = io_bus.in_valid & r_in_ready;
    assign w_pop        = (r_count != 2'd0) & io_bus.out_ready;
    assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
    assign w_wr_idx     = r_count - {1'b0, w_pop};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wr_en
            assign w_wr_en[gi] = w_push & (w_wr_idx == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != 2'd2);
        end
    end

    // Slot 0 is always the head; a pop shifts slot 1 down unless the new op lands there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            if (w_wr_en[0]) begin
                r_ent[0] <= w_new;
            end else if (w_pop) begin
                r_ent[0] <= r_ent[1];
            end
            if (w_wr_en[1]) begin
                r_ent[1] <= w_new;
            end
        end
    end

    assign io_bus.in_ready     = r_in_ready;
    assign io_bus.out_valid    = (r_count != 2'd0);
    assign io_bus.out_taken    = r_ent[0].taken;
    assign io_bus.out_misalign = r_ent[0].misalign;
    assign io_bus.out_target   = r_ent[0].target;
    assign io_bus.out_result   = {{(XLEN-1){1'b0}}, r_ent[0].result};

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_branches <= 32'd0;
            r_stat_taken    <= 32'd0;
        end else if (w_pop && r_ent[0].is_branch) begin
            r_stat_branches <= r_stat_branches + 32'd1;
            if (r_ent[0].taken) begin
                r_stat_taken <= r_stat_taken + 32'd1;
            end
        end
    end

    assign stat_branches = r_stat_branches;
    assign stat_taken    = r_stat_taken;
`else
    logic w_unused_head_is_branch;
    assign w_unused_head_is_branch = r_ent[0].is_branch;
`endif

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Randomized scoreboard bench for branch_resolve_stage; reference model works from the a/b operands that produced the flags.
module tb_branch_resolve_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_stage_if #(.XLEN(32)) bus ();

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_taken;
`endif

    branch_resolve_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .io_bus        (bus)
`ifdef BRANCH_RESOLVE_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_taken    (stat_taken)
`endif
    );

    typedef struct packed {
        logic        is_branch;
        logic        taken;
        logic        misalign;
        logic [31:0] target;
        logic [31:0] result;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   model_br = 0;
    int   model_tk = 0;
    int   n_out = 0;
    bit   rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    // Flags of a 32-bit a-b computed as a + ~b + 1.
    task automatic make_flags(input logic [31:0] a, input logic [31:0] b,
                              output logic n, output logic z, output logic c, output logic v);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        n = s[31];
        z = (s[31:0] == 32'd0);
        c = s[32];
        v = (a[31] != b[31]) && (s[31] != a[31]);
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc, input logic [31:0] imm);
        exp_t e;
        logic slt, sltu;
        slt  = ($signed(a) < $signed(b));
        sltu = (a < b);
        e = '0;
        e.target    = pc + imm;
        e.is_branch = (op == 2'd1);
        if (op == 2'd1) begin
            case (f3)
                3'd0: e.taken = (a == b);
                3'd1: e.taken = (a != b);
                3'd4: e.taken = slt;
                3'd5: e.taken = !slt;
                3'd6: e.taken = sltu;
                3'd7: e.taken = !sltu;
                default: e.taken = 1'b0;
            endcase
        end
        if (op == 2'd2) e.result = {31'd0, slt};
        if (op == 2'd3) e.result = {31'd0, sltu};
        e.misalign = e.taken && (e.target[1:0] != 2'b00);
        return e;
    endfunction

    // Drive one op, wait (bounded) for acceptance, then record its expected response.
    task automatic send(input logic [1:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm);
        logic n, z, c, v;
        bit   ok;
        make_flags(a, b, n, z, c, v);
        bus.in_op     = op;
        bus.in_funct3 = f3;
        bus.in_n      = n;
        bus.in_z      = z;
        bus.in_c      = c;
        bus.in_v      = v;
        bus.in_pc     = pc;
        bus.in_imm    = imm;
        bus.in_valid  = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            sb.push_back(model(op, f3, a, b, pc, imm));
        end else begin
            checks++;
            errors++;
            $display("FAIL send_accept: in_ready stayed 0 for 100 cycles, required 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 500 && sb.size() != 0; t++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d entries left, required 0", name, sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output handshake, and checks payload holds while stalled.
    initial begin
        exp_t        e;
        bit          stalled;
        logic        snap_taken;
        logic [31:0] snap_target;
        stalled = 1'b0;
        snap_taken = 1'b0;
        snap_target = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("hold_taken", {31'd0, bus.out_taken}, {31'd0, snap_taken});
                chk("hold_target", bus.out_target, snap_target);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: out_valid=1 with no pending op, required out_valid=0");
                end else begin
                    e = sb.pop_front();
                    n_out++;
                    chk("out_taken", {31'd0, bus.out_taken}, {31'd0, e.taken});
                    chk("out_target", bus.out_target, e.target);
                    chk("out_result", bus.out_result, e.result);
                    chk("out_misalign", {31'd0, bus.out_misalign}, {31'd0, e.misalign});
                    $display("out #%0d: taken=%0b target=0x%08h result=%0d misalign=%0b",
                             n_out, bus.out_taken, bus.out_target, bus.out_result, bus.out_misalign);
                    if (e.is_branch) model_br++;
                    if (e.is_branch && e.taken) model_tk++;
                end
            end
            stalled     = bus.out_valid && !bus.out_ready;
            snap_taken  = bus.out_taken;
            snap_target = bus.out_target;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [31:0] a, b, pc, imm;

        bus.in_valid  = 1'b0;
        bus.in_op     = 2'd0;
        bus.in_funct3 = 3'd0;
        bus.in_n      = 1'b0;
        bus.in_z      = 1'b0;
        bus.in_c      = 1'b0;
        bus.in_v      = 1'b0;
        bus.in_pc     = 32'd0;
        bus.in_imm    = 32'd0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_taken", {31'd0, bus.out_taken}, 32'd0);
        chk("rst_target", bus.out_target, 32'd0);
        chk("rst_result", bus.out_result, 32'd0);
        chk("rst_misalign", {31'd0, bus.out_misalign}, 32'd0);

        // BEQ taken, one-cycle latency
        bus.out_ready = 1'b1;
        send(2'd1, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20);
        chk("t1_latency_valid", {31'd0, bus.out_valid}, 32'd1);

        // BLT/BLTU/SLTU/SLT with a=-1, b=1
        send(2'd1, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
        send(2'd1, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
        send(2'd3, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        send(2'd2, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);

        // Signed overflow BGE, wrapping target
        send(2'd1, 3'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'd8);

        // Misaligned target: taken vs not taken
        send(2'd1, 3'd0, 32'd7, 32'd7, 32'h200, 32'h2);
        send(2'd1, 3'd1, 32'd7, 32'd7, 32'h200, 32'h2);

        // Illegal branch funct3
        send(2'd1, 3'd2, 32'd3, 32'd3, 32'h300, 32'h6);
        send(2'd1, 3'd3, 32'd3, 32'd9, 32'h300, 32'h6);
        drain("directed");

        // Fill the skid buffer while stalled, then drain with overlapping push/pop
        bus.out_ready = 1'b0;
        send(2'd1, 3'd0, 32'd1, 32'd1, 32'h1000, 32'h10);
        send(2'd2, 3'd0, 32'd2, 32'd9, 32'h2000, 32'h20);
        chk("t4_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("t4_full_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t4_head_target", bus.out_target, 32'h1010);
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(2'd1, 3'd7, 32'd4, 32'd9, 32'h3000, 32'h30);
        send(2'd3, 3'd0, 32'd4, 32'd9, 32'h4000, 32'h40);
        chk("t4_stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t4_stream_out_valid", {31'd0, bus.out_valid}, 32'd1);
        drain("stall");

        // Randomized traffic with random back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op  = 2'($urandom_range(0, 3));
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a + 32'($urandom_range(0, 2)) - 32'd1;
                2: b = {a[31] ^ 1'b1, a[30:0]};
                default: b = $urandom;
            endcase
            pc  = $urandom;
            imm = $urandom;
            send(op, f3, a, b, pc, imm);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        drain("random");

`ifdef BRANCH_RESOLVE_STATS_EN
        chk("stat_branches", stat_branches, 32'(model_br));
        chk("stat_taken", stat_taken, 32'(model_tk));
`endif

        // Reset with two entries held
        bus.out_ready = 1'b0;
        send(2'd1, 3'd0, 32'd8, 32'd8, 32'h500, 32'h4);
        send(2'd1, 3'd4, 32'd1, 32'd8, 32'h600, 32'h8);
        chk("t6_pre_out_valid", {31'd0, bus.out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        sb.delete();
        model_br = 0;
        model_tk = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_target", bus.out_target, 32'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
        chk("t6_stat_branches", stat_branches, 32'd0);
        chk("t6_stat_taken", stat_taken, 32'd0);
`endif

        // Recovery after reset
        bus.out_ready = 1'b1;
        send(2'd1, 3'd1, 32'd3, 32'd4, 32'h700, 32'hC);
        drain("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
